// File: rtl/approx_mon_pkg.sv
// rtl/approx_mon_pkg.sv - shared types and width constants for the approximate-adder monitors
// Purpose: FSM state encoding, default operand/counter widths and the derived
//          error-sum accumulator width.
// Ports:   none (package).
package approx_mon_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 16;

  // Summing up to 2^cnt_w-1 values of at most 2^width-1 needs cnt_w+width bits.
  function automatic int sum_ed_w(input int cnt_w, input int width);
    return cnt_w + width;
  endfunction

  localparam int SUM_ED_W = sum_ed_w(CNT_W_DEF, WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/approx_adder_error_monitor_if.sv
// rtl/approx_adder_error_monitor_if.sv - sample bus carrying operands and approximate sum
// Purpose: groups one adder sample plus its valid/ready handshake.
// Ports:   in_valid/in_ready handshake; in_a, in_b, in_cin operands; in_sum approximate sum.
//          master = sample producer, slave = monitor.
interface approx_adder_error_monitor_if
  import approx_mon_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [WIDTH-1:0] in_sum;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sum,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sum,
    output in_ready
  );

endinterface

// File: rtl/approx_err_distance.sv
// rtl/approx_err_distance.sv - exact sum and unsigned error distance of one adder sample
// Purpose: combinational reference add and |exact - approximate| without wrap.
// Ports:   a, b, cin  operands; sum approximate sum under test;
//          exact_sum  (a+b+cin) mod 2^WIDTH; ed larger-minus-smaller distance.
module approx_err_distance
  import approx_mon_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] exact_sum,
  output logic [WIDTH-1:0] ed
);

  // Carry-out is deliberately dropped: only the WIDTH-bit sums are compared.
  always_comb begin
    exact_sum = a + b + WIDTH'(cin);
    ed        = (exact_sum >= sum) ? (exact_sum - sum) : (sum - exact_sum);
  end

endmodule

// File: rtl/approx_adder_error_monitor.sv
// rtl/approx_adder_error_monitor.sv - error-rate / error-distance collector for approximate adders
// Purpose: over a run of N samples accumulates error count, summed and maximum error
//          distance, and the operands of the first sample that reached the maximum.
// Ports:   clk, rst (sync, active high); start + num_samples begin a run;
//          smp sample bus (slave); busy = running; results_valid = stats final;
//          err_count, sum_ed, max_ed, max_a, max_b statistics.
module approx_adder_error_monitor
  import approx_mon_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [CNT_W-1:0]                     num_samples,
  approx_adder_error_monitor_if.slave          smp,
  output logic                                 busy,
  output logic                                 results_valid,
  output logic [CNT_W-1:0]                     err_count,
  output logic [sum_ed_w(CNT_W, WIDTH)-1:0]    sum_ed,
  output logic [WIDTH-1:0]                     max_ed,
  output logic [WIDTH-1:0]                     max_a,
  output logic [WIDTH-1:0]                     max_b
);

  localparam int SUM_W = sum_ed_w(CNT_W, WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] accepted_q;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_ed_q;

  logic [CNT_W-1:0] err_count_q;
  logic [SUM_W-1:0] sum_ed_q;
  logic [WIDTH-1:0] max_ed_q, max_a_q, max_b_q;

  logic [WIDTH-1:0] ed;
  logic [WIDTH-1:0] unused_exact_sum;
  logic             ready;
  logic             accept;
  logic             clear;

  approx_err_distance #(.WIDTH(WIDTH)) u_ed (
    .a         (smp.in_a),
    .b         (smp.in_b),
    .cin       (smp.in_cin),
    .sum       (smp.in_sum),
    .exact_sum (unused_exact_sum),
    .ed        (ed)
  );

  assign ready         = (state_q == RUN) && (accepted_q < n_q);
  assign accept        = smp.in_valid && ready;
  // start is only honoured outside RUN; a mid-run start must not disturb the stats.
  assign clear         = start && (state_q != RUN);
  assign smp.in_ready  = ready;
  assign busy          = (state_q == RUN);
  assign results_valid = (state_q == DONE);
  assign err_count     = err_count_q;
  assign sum_ed        = sum_ed_q;
  assign max_ed        = max_ed_q;
  assign max_a         = max_a_q;
  assign max_b         = max_b_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = (num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Wait for the last accepted sample to drain out of stage 1.
        if ((accepted_q == n_q) && !s1_valid_q) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      accepted_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_ed_q     <= '0;
      err_count_q <= '0;
      sum_ed_q    <= '0;
      max_ed_q    <= '0;
      max_a_q     <= '0;
      max_b_q     <= '0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        n_q         <= num_samples;
        accepted_q  <= '0;
        s1_valid_q  <= 1'b0;
        err_count_q <= '0;
        sum_ed_q    <= '0;
        max_ed_q    <= '0;
        max_a_q     <= '0;
        max_b_q     <= '0;
      end else begin
        // Stage 0 -> 1: capture the sample and its distance.
        s1_valid_q <= accept;
        if (accept) begin
          s1_a_q     <= smp.in_a;
          s1_b_q     <= smp.in_b;
          s1_ed_q    <= ed;
          accepted_q <= accepted_q + CNT_W'(1);
        end
        // Stage 1 -> stats, overlapping with the next accept for full throughput.
        if (s1_valid_q) begin
          err_count_q <= err_count_q + CNT_W'(s1_ed_q != '0);
          sum_ed_q    <= sum_ed_q + SUM_W'(s1_ed_q);
          // Strictly greater: on ties the earlier sample's operands are kept.
          if (s1_ed_q > max_ed_q) begin
            max_ed_q <= s1_ed_q;
            max_a_q  <= s1_a_q;
            max_b_q  <= s1_b_q;
          end
        end
      end
    end
  end

endmodule
